// File: rtl/csr_exec_ctrl_pkg.sv
// Shared definitions for the CSR instruction execution controller: bus widths,
// funct3 encodings, access levels, ALU ops and FSM state encoding.
package csr_exec_ctrl_pkg;

  localparam int REG_BUS_W  = 32;
  localparam int CSR_ADDR_W = 12;
  localparam int REG_IDX_W  = 5;

  localparam logic WRITE_EN = 1'b1;
  localparam logic READ_EN  = 1'b0;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  // funct3[1:0] selects the read-modify-write flavour; funct3[2] selects the immediate form.
  typedef enum logic [1:0] {
    ALU_NONE = 2'b00,
    ALU_RW   = 2'b01,
    ALU_RS   = 2'b10,
    ALU_RC   = 2'b11
  } csr_alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } csr_state_e;

  function automatic logic f3_valid(input logic [2:0] f3);
    return f3[1:0] != 2'b00;
  endfunction

  function automatic logic csr_read_only(input logic [CSR_ADDR_W-1:0] addr);
    return addr[CSR_ADDR_W-1:CSR_ADDR_W-2] == 2'b11;
  endfunction

endpackage

// File: rtl/csr_exec_ctrl_if.sv
// Bundles the decoder, CSR register-file and GPR write-back signals of the CSR controller.
interface csr_exec_ctrl_if;
  import csr_exec_ctrl_pkg::*;

  // Handshake: start_i is a single-cycle request qualified only while busy_o is low;
  // there is no back-pressure, a request seen while busy is dropped, and done_o marks completion.
  logic                  start_i;
  logic [2:0]            funct3_i;
  logic [CSR_ADDR_W-1:0] csr_addr_i;
  logic [REG_IDX_W-1:0]  rs1_idx_i;
  logic [REG_BUS_W-1:0]  rs1_data_i;
  logic [REG_IDX_W-1:0]  rd_idx_i;

  logic [CSR_ADDR_W-1:0] csr_addr_o;
  logic                  csr_we_o;
  logic [REG_BUS_W-1:0]  csr_wdata_o;
  logic [REG_BUS_W-1:0]  csr_rdata_i;

  logic                  rd_we_o;
  logic [REG_IDX_W-1:0]  rd_idx_o;
  logic [REG_BUS_W-1:0]  rd_wdata_o;

  logic                  busy_o;
  logic                  done_o;
  logic                  illegal_o;
  logic                  inst_succ_o;

  modport master (
    output start_i, funct3_i, csr_addr_i, rs1_idx_i, rs1_data_i, rd_idx_i, csr_rdata_i,
    input  csr_addr_o, csr_we_o, csr_wdata_o, rd_we_o, rd_idx_o, rd_wdata_o,
    input  busy_o, done_o, illegal_o, inst_succ_o
  );

  modport slave (
    input  start_i, funct3_i, csr_addr_i, rs1_idx_i, rs1_data_i, rd_idx_i, csr_rdata_i,
    output csr_addr_o, csr_we_o, csr_wdata_o, rd_we_o, rd_idx_o, rd_wdata_o,
    output busy_o, done_o, illegal_o, inst_succ_o
  );

endinterface

// File: rtl/csr_exec_ctrl_alu.sv
// Combinational CSR read-modify-write: computes the new CSR value from the old one.
module csr_alu
  import csr_exec_ctrl_pkg::*;
(
  input  csr_alu_op_e          op_i,
  input  logic [REG_BUS_W-1:0] old_i,
  input  logic [REG_BUS_W-1:0] operand_i,
  output logic [REG_BUS_W-1:0] new_o
);

  always_comb begin
    new_o = operand_i;
    case (op_i)
      ALU_RS:  new_o = old_i | operand_i;
      ALU_RC:  new_o = old_i & ~operand_i;
      default: new_o = operand_i;
    endcase
  end

endmodule

// File: rtl/csr_exec_ctrl.sv
// CSR instruction sequencer: read the CSR, optionally write the modified value,
// then write the old value back to rd and pulse completion.
module csr_exec_ctrl
  import csr_exec_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  csr_exec_ctrl_if.slave bus,
  output csr_state_e    state_o
);

  csr_state_e            state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [CSR_ADDR_W-1:0] addr_q, addr_d;
  logic [REG_IDX_W-1:0]  rs1_idx_q, rs1_idx_d;
  logic [REG_BUS_W-1:0]  rs1_data_q, rs1_data_d;
  logic [REG_IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic [REG_BUS_W-1:0]  old_q, old_d;
  logic                  illegal_q, illegal_d;

  logic [REG_BUS_W-1:0]  operand;
  logic [REG_BUS_W-1:0]  new_val;
  logic                  wr_en;

  logic [CSR_ADDR_W-1:0] csr_addr_c;
  logic                  csr_we_c;
  logic [REG_BUS_W-1:0]  csr_wdata_c;
  logic                  rd_we_c;
  logic [REG_IDX_W-1:0]  rd_idx_c;
  logic [REG_BUS_W-1:0]  rd_wdata_c;
  logic                  done_c;
  logic                  illegal_c;
  logic                  succ_c;

  assign operand = op_q[2] ? {{(REG_BUS_W-REG_IDX_W){1'b0}}, rs1_idx_q} : rs1_data_q;
  // Set/clear with a zero source register is a pure read and never counts as a write.
  assign wr_en   = (op_q[1:0] == ALU_RW) || (rs1_idx_q != '0);

  csr_alu u_alu (
    .op_i      (csr_alu_op_e'(op_q[1:0])),
    .old_i     (old_q),
    .operand_i (operand),
    .new_o     (new_val)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    rs1_idx_d   = rs1_idx_q;
    rs1_data_d  = rs1_data_q;
    rd_idx_d    = rd_idx_q;
    old_d       = old_q;
    illegal_d   = illegal_q;
    csr_addr_c  = '0;
    csr_we_c    = READ_EN;
    csr_wdata_c = '0;
    rd_we_c     = 1'b0;
    rd_idx_c    = '0;
    rd_wdata_c  = '0;
    done_c      = 1'b0;
    illegal_c   = 1'b0;
    succ_c      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          if (f3_valid(bus.funct3_i)) begin
            op_d       = bus.funct3_i;
            addr_d     = bus.csr_addr_i;
            rs1_idx_d  = bus.rs1_idx_i;
            rs1_data_d = bus.rs1_data_i;
            rd_idx_d   = bus.rd_idx_i;
            illegal_d  = 1'b0;
            state_d    = ST_READ;
          end else begin
            illegal_d  = 1'b1;
            state_d    = ST_DONE;
          end
        end
      end
      ST_READ: begin
        csr_addr_c = addr_q;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        csr_addr_c = addr_q;
        old_d      = bus.csr_rdata_i;
        if (wr_en && csr_read_only(addr_q)) begin
          illegal_d = 1'b1;
          state_d   = ST_DONE;
        end else if (wr_en) begin
          state_d   = ST_WRITE;
        end else begin
          state_d   = ST_DONE;
        end
      end
      ST_WRITE: begin
        csr_addr_c  = addr_q;
        csr_we_c    = WRITE_EN;
        csr_wdata_c = new_val;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        done_c    = 1'b1;
        illegal_c = illegal_q;
        succ_c    = !illegal_q;
        if (!illegal_q && (rd_idx_q != '0)) begin
          rd_we_c    = 1'b1;
          rd_idx_c   = rd_idx_q;
          rd_wdata_c = old_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All outputs decode from state_q, so an async reset zeroes them immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      rs1_idx_q  <= '0;
      rs1_data_q <= '0;
      rd_idx_q   <= '0;
      old_q      <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      rs1_idx_q  <= rs1_idx_d;
      rs1_data_q <= rs1_data_d;
      rd_idx_q   <= rd_idx_d;
      old_q      <= old_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.csr_addr_o  = csr_addr_c;
  assign bus.csr_we_o    = csr_we_c;
  assign bus.csr_wdata_o = csr_wdata_c;
  assign bus.rd_we_o     = rd_we_c;
  assign bus.rd_idx_o    = rd_idx_c;
  assign bus.rd_wdata_o  = rd_wdata_c;
  assign bus.busy_o      = (state_q != ST_IDLE);
  assign bus.done_o      = done_c;
  assign bus.illegal_o   = illegal_c;
  assign bus.inst_succ_o = succ_c;
  assign state_o         = state_q;

endmodule

// File: tb/tb_csr_exec_ctrl.sv
// Bench for csr_exec_ctrl: directed and random CSR instructions against a behavioural
// model, with a CSR register file emulated inside the bench.
module tb_csr_exec_ctrl;
  import csr_exec_ctrl_pkg::*;

  logic       clk;
  logic       rst_n;
  csr_state_e state_o;

  csr_exec_ctrl_if bus ();

  csr_exec_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] csr_file [4096];
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},    32'(bus.busy_o), 0);
    check({tag, "_we"},      32'(bus.csr_we_o), 0);
    check({tag, "_addr"},    32'(bus.csr_addr_o), 0);
    check({tag, "_wdata"},   bus.csr_wdata_o, 0);
    check({tag, "_done"},    32'(bus.done_o), 0);
    check({tag, "_illegal"}, 32'(bus.illegal_o), 0);
    check({tag, "_succ"},    32'(bus.inst_succ_o), 0);
    check({tag, "_rd"},      {bus.rd_we_o, 21'd0, bus.rd_idx_o, 5'd0} | bus.rd_wdata_o, 0);
    check({tag, "_state"},   32'(state_o), 32'(ST_IDLE));
  endtask

  // driver + reference model for one instruction
  task automatic run_inst(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1,
                          input logic [31:0] data, input logic [4:0] rd, input bit hold);
    bit          valid, imm, wr_en, illegal, exp_write, exp_rd_we;
    logic [31:0] old, operand, new_v;
    int          lat, done_cyc, wr_cyc, stray, busy_low, n_wr;
    logic        ill_d, succ_d, rdwe_d;
    logic [4:0]  rdidx_d;
    logic [31:0] rdw_d, wr_addr;
    logic [11:0] last_addr;

    valid     = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b011) ||
                (f3 == 3'b101) || (f3 == 3'b110) || (f3 == 3'b111);
    imm       = (f3 >= 3'b101);
    operand   = imm ? {27'd0, rs1} : data;
    old       = valid ? csr_file[addr] : 32'd0;
    wr_en     = (f3 == 3'b001) || (f3 == 3'b101) || (rs1 != 0);
    illegal   = !valid || (wr_en && (addr >= 12'hC00));
    exp_write = !illegal && wr_en;
    exp_rd_we = !illegal && (rd != 0);
    if (f3 == 3'b001 || f3 == 3'b101)      new_v = operand;
    else if (f3 == 3'b010 || f3 == 3'b110) new_v = old | operand;
    else                                   new_v = old & ~operand;
    lat = !valid ? 1 : (exp_write ? 4 : 3);
    if (exp_write) exp_q.push_back(new_v);

    done_cyc = 0; wr_cyc = 0; stray = 0; busy_low = 0; n_wr = 0;
    ill_d = 0; succ_d = 0; rdwe_d = 0; rdidx_d = 0; rdw_d = 0; wr_addr = 0; last_addr = 0;

    bus.start_i    = 1'b1;
    bus.funct3_i   = f3;
    bus.csr_addr_i = addr;
    bus.rs1_idx_i  = rs1;
    bus.rs1_data_i = data;
    bus.rd_idx_i   = rd;
    @(posedge clk);
    #1;
    if (!hold) begin
      bus.start_i    = 1'b0;
      bus.funct3_i   = 3'($urandom_range(0, 7));
      bus.csr_addr_i = 12'($urandom);
      bus.rs1_idx_i  = 5'($urandom);
      bus.rs1_data_i = $urandom;
      bus.rd_idx_i   = 5'($urandom);
    end

    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.busy_o !== 1'b1) busy_low++;
      if (bus.csr_we_o === 1'b1) begin
        n_wr++;
        wr_cyc  = k;
        wr_addr = 32'(bus.csr_addr_o);
        check("wr_expected", exp_q.size(), 1);
        if (exp_q.size() > 0) check("csr_wdata", bus.csr_wdata_o, exp_q.pop_front());
      end else if (bus.csr_wdata_o !== 32'd0) begin
        stray++;
      end
      if (bus.done_o === 1'b1) begin
        done_cyc = k;
        ill_d    = bus.illegal_o;
        succ_d   = bus.inst_succ_o;
        rdwe_d   = bus.rd_we_o;
        rdidx_d  = bus.rd_idx_o;
        rdw_d    = bus.rd_wdata_o;
      end else if ((bus.illegal_o | bus.inst_succ_o | bus.rd_we_o) !== 1'b0 ||
                   bus.rd_idx_o !== 5'd0 || bus.rd_wdata_o !== 32'd0) begin
        stray++;
      end
      // emulated CSR file: registered read, write applied on the write cycle
      bus.csr_rdata_i = csr_file[last_addr];
      last_addr       = bus.csr_addr_o;
      if (bus.csr_we_o === 1'b1) csr_file[bus.csr_addr_o] = bus.csr_wdata_o;
      if (done_cyc != 0) break;
    end

    check("done_cycle", done_cyc, lat);
    check("csr_writes", n_wr, exp_write ? 1 : 0);
    if (exp_write) begin
      check("write_cycle", wr_cyc, 3);
      check("write_addr", wr_addr, 32'(addr));
    end
    if (valid) check("csr_final", csr_file[addr], exp_write ? new_v : old);
    check("illegal_pulse", 32'(ill_d), 32'(illegal));
    check("succ_pulse", 32'(succ_d), 32'(!illegal));
    check("rd_we", 32'(rdwe_d), 32'(exp_rd_we));
    check("rd_idx", 32'(rdidx_d), exp_rd_we ? 32'(rd) : 0);
    check("rd_wdata", rdw_d, exp_rd_we ? old : 0);
    check("stray_outputs", stray, 0);
    check("busy_during", busy_low, 0);
    while (exp_q.size() > 0) begin
      check("missing_write", exp_q.size(), 0);
      void'(exp_q.pop_front());
    end

    @(negedge clk);
    check("busy_after", 32'(bus.busy_o), 0);
    check("done_after", 32'(bus.done_o), 0);
    bus.start_i = 1'b0;
    @(negedge clk);
    check("not_queued", 32'(bus.busy_o), 0);
  endtask

  initial begin : stimulus
    logic [2:0]  f3;
    logic [11:0] a;
    logic [4:0]  r1, rdi;
    int          stray;

    rst_n          = 1'b0;
    bus.start_i    = 1'b0;
    bus.funct3_i   = '0;
    bus.csr_addr_i = '0;
    bus.rs1_idx_i  = '0;
    bus.rs1_data_i = '0;
    bus.rd_idx_i   = '0;
    bus.csr_rdata_i = '0;
    for (int i = 0; i < 4096; i++) csr_file[i] = $urandom;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // directed cases
    csr_file[12'h340] = 32'h11;
    run_inst(F3_CSRRW, 12'h340, 5'd1, 32'hDEADBEEF, 5'd5, 1'b0);
    csr_file[12'h300] = 32'h1;
    run_inst(F3_CSRRS, 12'h300, 5'd2, 32'h8, 5'd3, 1'b0);
    run_inst(F3_CSRRC, 12'h300, 5'd4, 32'h1, 5'd3, 1'b0);
    check("rs_rc_result", csr_file[12'h300], 32'h8);
    csr_file[12'hB00] = 32'h0000_1234;
    run_inst(F3_CSRRSI, 12'hB00, 5'd0, 32'hFFFF_FFFF, 5'd7, 1'b0);
    run_inst(F3_CSRRW, 12'hF14, 5'd1, 32'hA5A5_A5A5, 5'd9, 1'b0);
    run_inst(3'b000, 12'h340, 5'd1, 32'h1, 5'd2, 1'b0);
    run_inst(3'b100, 12'h340, 5'd1, 32'h1, 5'd2, 1'b0);
    run_inst(F3_CSRRS, 12'hC00, 5'd0, 32'h1, 5'd8, 1'b0);
    run_inst(F3_CSRRCI, 12'hBFF, 5'd31, 32'h0, 5'd0, 1'b0);
    run_inst(F3_CSRRWI, 12'h341, 5'd31, 32'h0, 5'd2, 1'b1);

    // reset during WAIT aborts the instruction
    csr_file[12'h305] = 32'hCAFE_0001;
    bus.start_i    = 1'b1;
    bus.funct3_i   = F3_CSRRW;
    bus.csr_addr_i = 12'h305;
    bus.rs1_idx_i  = 5'd3;
    bus.rs1_data_i = 32'h1234_5678;
    bus.rd_idx_i   = 5'd4;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_in_wait", 32'(state_o), 32'(ST_WAIT));
    rst_n = 1'b0;
    #1;
    check_outputs_zero("abort");
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if ((bus.csr_we_o | bus.done_o | bus.inst_succ_o | bus.rd_we_o) !== 1'b0) stray++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if ((bus.csr_we_o | bus.done_o | bus.inst_succ_o | bus.rd_we_o) !== 1'b0) stray++;
    end
    check("abort_pulses", stray, 0);
    check("abort_state", 32'(state_o), 32'(ST_IDLE));
    check("abort_no_write", csr_file[12'h305], 32'hCAFE_0001);

    // random instructions
    for (int n = 0; n < 40; n++) begin
      f3  = 3'($urandom_range(0, 7));
      a   = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 3) == 0) a[11:10] = 2'b11;
      r1  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rdi = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      run_inst(f3, a, r1, $urandom, rdi, 1'($urandom_range(0, 1)));
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
